devil_cmd_sequencer: RTL and testbench

//  Next-generation attack-command controller for the ACE devil path: queues commands (REROUTING/LEAK/POISON)

---
 rtl/devil_cmd_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_devil_cmd_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/devil_cmd_sequencer.sv
// ACE devil-path command sequencer: queued commands, start/done issue FSM with timeout, programmable monitor pattern.
// Optional build macro DEVIL_CTRL_FLUSH_ON_ERROR_EN: any failed operation empties the command queue.
module devil_cmd_sequencer #(
   parameter int  C_S_AXI_DATA_WIDTH = 32,
   parameter int  C_ACE_DATA_WIDTH   = 128,
   parameter int  C_ACE_ADDR_WIDTH   = 44,
   parameter int  DEVIL_STATE_SIZE   = 5,
   parameter int  CMD_FIFO_DEPTH     = 4,
   parameter int  TIMEOUT_CYCLES     = 1024,
   localparam int PAT_W = C_ACE_DATA_WIDTH * 4,
   localparam int NW    = PAT_W / C_S_AXI_DATA_WIDTH,
   localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1,
   localparam int PTR_W = $clog2(CMD_FIFO_DEPTH),
   localparam int CNT_W = PTR_W + 1,
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                          ace_aclk,
   input  logic                          ace_areset,
   input  logic                          i_enable,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic [3:0]                    i_cmd,
   input  logic [C_ACE_ADDR_WIDTH-1:0]   i_cmd_addr,
   output logic                          o_op_start,
   output logic [1:0]                    o_op_cmd,
   output logic [C_ACE_ADDR_WIDTH-1:0]   o_op_addr,
   input  logic                          i_op_done,
   input  logic                          i_op_error,
   input  logic                          i_pat_wr_en,
   input  logic [IDX_W-1:0]              i_pat_wr_idx,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] i_pat_wr_data,
   output logic [PAT_W-1:0]              o_cache_line_2_monitor,
   output logic [DEVIL_STATE_SIZE-1:0]   o_fsm_devil_controller,
   output logic [CNT_W-1:0]              o_cmd_count,
   output logic [15:0]                   o_done_cnt,
   output logic [15:0]                   o_err_cnt
);

   typedef enum logic [DEVIL_STATE_SIZE-1:0] {
      ST_IDLE      = DEVIL_STATE_SIZE'(0),
      ST_FETCH     = DEVIL_STATE_SIZE'(1),
      ST_ISSUE     = DEVIL_STATE_SIZE'(2),
      ST_WAIT_DONE = DEVIL_STATE_SIZE'(3),
      ST_END_OP    = DEVIL_STATE_SIZE'(4)
   } state_e;

   state_e                      state_q, state_d;
   logic [3:0]                  cmd_mem_q  [CMD_FIFO_DEPTH];
   logic [3:0]                  cmd_mem_d  [CMD_FIFO_DEPTH];
   logic [C_ACE_ADDR_WIDTH-1:0] addr_mem_q [CMD_FIFO_DEPTH];
   logic [C_ACE_ADDR_WIDTH-1:0] addr_mem_d [CMD_FIFO_DEPTH];
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic [1:0]                  op_cmd_q, op_cmd_d;
   logic [C_ACE_ADDR_WIDTH-1:0] op_addr_q, op_addr_d;
   logic [TMR_W-1:0]            timer_q, timer_d;
   logic [15:0]                 done_cnt_q, done_cnt_d, err_cnt_q, err_cnt_d;
   logic [PAT_W-1:0]            pat_q, pat_d;

   logic [3:0]                  head_cmd;
   logic [C_ACE_ADDR_WIDTH-1:0] head_addr;
   logic                        head_valid, push, pop, timeout, op_ok, op_fail, flush, ready;

   always_comb begin
      head_cmd   = cmd_mem_q[rd_ptr_q];
      head_addr  = addr_mem_q[rd_ptr_q];
      head_valid = (head_cmd <= 4'd2);
      ready      = (count_q != CNT_W'(CMD_FIFO_DEPTH));
      push       = i_cmd_valid && ready;
      pop        = (state_q == ST_FETCH);
      timeout    = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
      op_ok      = (state_q == ST_WAIT_DONE) && i_op_done;
      op_fail    = ((state_q == ST_FETCH) && !head_valid) ||
                   ((state_q == ST_WAIT_DONE) && i_op_done && i_op_error) ||
                   ((state_q == ST_WAIT_DONE) && !i_op_done && timeout);
   end

`ifdef DEVIL_CTRL_FLUSH_ON_ERROR_EN
   // op_fail only fires on the transition into END_OP, so the flag is valid exactly during END_OP.
   logic err_flag_q;

   always_ff @(posedge ace_aclk or posedge ace_areset) begin
      if (ace_areset) err_flag_q <= 1'b0;
      else            err_flag_q <= op_fail;
   end

   always_comb flush = (state_q == ST_END_OP) && err_flag_q;
`else
   always_comb flush = 1'b0;
`endif

   always_ff @(posedge ace_aclk or posedge ace_areset) begin
      if (ace_areset) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if ((count_q != '0) && i_enable) state_d = ST_FETCH;
         ST_FETCH:     state_d = head_valid ? ST_ISSUE : ST_END_OP;
         ST_ISSUE:     state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (i_op_done || timeout) state_d = ST_END_OP;
         ST_END_OP:    state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_op_start             = (state_q == ST_ISSUE);
      o_fsm_devil_controller = state_q;
      o_cmd_ready            = ready;
      o_cmd_count            = count_q;
      o_op_cmd               = op_cmd_q;
      o_op_addr              = op_addr_q;
      o_done_cnt             = done_cnt_q;
      o_err_cnt              = err_cnt_q;
      o_cache_line_2_monitor = pat_q;
   end

   // A flush overrides any same-cycle push.
   always_comb begin
      cmd_mem_d  = cmd_mem_q;
      addr_mem_d = addr_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            cmd_mem_d[wr_ptr_q]  = i_cmd;
            addr_mem_d[wr_ptr_q] = i_cmd_addr;
            wr_ptr_d             = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      op_cmd_d   = op_cmd_q;
      op_addr_d  = op_addr_q;
      timer_d    = timer_q;
      done_cnt_d = done_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (pop && head_valid) begin
         op_cmd_d  = head_cmd[1:0];
         op_addr_d = head_addr;
      end
      if (state_q == ST_ISSUE)          timer_d = '0;
      else if (state_q == ST_WAIT_DONE) timer_d = timer_q + 1'b1;
      if (op_ok && (done_cnt_q != '1))   done_cnt_d = done_cnt_q + 16'd1;
      if (op_fail && (err_cnt_q != '1))  err_cnt_d  = err_cnt_q + 16'd1;
   end

   always_comb begin
      pat_d = pat_q;
      for (int unsigned w = 0; w < NW; w++) begin
         if (i_pat_wr_en && (i_pat_wr_idx == IDX_W'(w)))
            pat_d[w*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = i_pat_wr_data;
      end
   end

   always_ff @(posedge ace_aclk or posedge ace_areset) begin
      if (ace_areset) begin
         for (int unsigned i = 0; i < CMD_FIFO_DEPTH; i++) begin
            cmd_mem_q[i]  <= '0;
            addr_mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         op_cmd_q   <= '0;
         op_addr_q  <= '0;
         timer_q    <= '0;
         done_cnt_q <= '0;
         err_cnt_q  <= '0;
         pat_q      <= '0;
      end else begin
         cmd_mem_q  <= cmd_mem_d;
         addr_mem_q <= addr_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         op_cmd_q   <= op_cmd_d;
         op_addr_q  <= op_addr_d;
         timer_q    <= timer_d;
         done_cnt_q <= done_cnt_d;
         err_cnt_q  <= err_cnt_d;
         pat_q      <= pat_d;
      end
   end

endmodule

// File: tb/tb_devil_cmd_sequencer.sv
// Self-checking bench for devil_cmd_sequencer: issue scoreboard, command/pattern vector tables, corner sequences.
module tb_devil_cmd_sequencer;
   localparam int AW  = 44;
   localparam int PW  = 512;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_enable, i_cmd_valid, o_cmd_ready;
   logic [3:0]    i_cmd;
   logic [AW-1:0] i_cmd_addr, o_op_addr;
   logic          o_op_start;
   logic [1:0]    o_op_cmd;
   logic          i_op_done, i_op_error, i_pat_wr_en;
   logic [3:0]    i_pat_wr_idx;
   logic [31:0]   i_pat_wr_data;
   logic [PW-1:0] o_pat;
   logic [4:0]    o_state;
   logic [2:0]    o_cmd_count;
   logic [15:0]   o_done_cnt, o_err_cnt;

   devil_cmd_sequencer #(
      .C_S_AXI_DATA_WIDTH(32), .C_ACE_DATA_WIDTH(128), .C_ACE_ADDR_WIDTH(AW),
      .DEVIL_STATE_SIZE(5), .CMD_FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .ace_aclk(clk), .ace_areset(rst), .i_enable(i_enable),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd(i_cmd), .i_cmd_addr(i_cmd_addr),
      .o_op_start(o_op_start), .o_op_cmd(o_op_cmd), .o_op_addr(o_op_addr),
      .i_op_done(i_op_done), .i_op_error(i_op_error),
      .i_pat_wr_en(i_pat_wr_en), .i_pat_wr_idx(i_pat_wr_idx), .i_pat_wr_data(i_pat_wr_data),
      .o_cache_line_2_monitor(o_pat), .o_fsm_devil_controller(o_state), .o_cmd_count(o_cmd_count),
      .o_done_cnt(o_done_cnt), .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic [1:0] cmd; logic [AW-1:0] addr; } exp_t;
   typedef struct { logic [3:0] cmd; logic [AW-1:0] addr; bit err; int d_done; int d_err; } cvec_t;
   typedef struct { logic [3:0] idx; logic [31:0] data; logic [31:0] exp_top; } pvec_t;

   exp_t          sb[$];
   int            checks = 0;
   int            failures = 0;
   int            starts_seen = 0;
   int            exp_done = 0;
   int            exp_err = 0;
   logic [PW-1:0] pat_model = '0;

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : issue_monitor
      exp_t e;
      if (o_op_start === 1'b1) begin
         starts_seen++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_start: got cmd=%0d addr=%0h expected no issue", o_op_cmd, o_op_addr);
         end else begin
            e = sb.pop_front();
            check("issue_cmd", PW'(o_op_cmd), PW'(e.cmd));
            check("issue_addr", PW'(o_op_addr), PW'(e.addr));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] c, input logic [AW-1:0] a, input bit expect_issue);
      exp_t e;
      logic acc;
      i_cmd_valid = 1'b1;
      i_cmd       = c;
      i_cmd_addr  = a;
      acc         = o_cmd_ready;
      if (acc && (c <= 4'd2) && expect_issue) begin
         e.cmd  = c[1:0];
         e.addr = a;
         sb.push_back(e);
      end
      tick();
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_state(input logic [4:0] s, input string name);
      int n = 0;
      while (o_state !== s && n < 200) begin
         tick();
         n++;
      end
      check(name, PW'(o_state), PW'(s));
   endtask

   task automatic run_op(input bit err);
      wait_state(5'd3, "reach_wait_done");
      i_op_done  = 1'b1;
      i_op_error = err;
      tick();
      i_op_done  = 1'b0;
      i_op_error = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      cvec_t cv[5];
      pvec_t pv[4];
      int    n;
      int    starts0;

      cv[0] = '{4'd0,  44'h0000_0000_ABC, 1'b0, 1, 0};
      cv[1] = '{4'd2,  44'hFFF_FFFF_FFFF, 1'b1, 1, 1};
      cv[2] = '{4'd1,  44'h000_1234_5678, 1'b0, 1, 0};
      cv[3] = '{4'd5,  44'h000_0000_0010, 1'b0, 0, 1};
      cv[4] = '{4'd15, 44'h000_0000_0020, 1'b0, 0, 1};
      pv[0] = '{4'd15, 32'hEB624E0D, 32'hEB624E0D};
      pv[1] = '{4'd0,  32'hDEADBEEF, 32'hEB624E0D};
      pv[2] = '{4'd7,  32'h12345678, 32'hEB624E0D};
      pv[3] = '{4'd15, 32'hA5A5A5A5, 32'hA5A5A5A5};

      rst = 1'b1; i_enable = 1'b0; i_cmd_valid = 1'b0; i_cmd = '0; i_cmd_addr = '0;
      i_op_done = 1'b0; i_op_error = 1'b0; i_pat_wr_en = 1'b0; i_pat_wr_idx = '0; i_pat_wr_data = '0;
      tick(); tick();
      check("rst_state", PW'(o_state), PW'(0));
      check("rst_ready", PW'(o_cmd_ready), PW'(1));
      check("rst_start", PW'(o_op_start), PW'(0));
      check("rst_count", PW'(o_cmd_count), PW'(0));
      check("rst_op", PW'({o_op_cmd, o_op_addr}), PW'(0));
      check("rst_cnts", PW'({o_done_cnt, o_err_cnt}), PW'(0));
      check("rst_pat", o_pat, '0);
      rst = 1'b0;
      i_enable = 1'b1;
      tick();

      // Latency: start pulse sits between edges N+2 and N+3 after the push edge N
      push(4'd1, 44'h1000, 1'b1);
      @(negedge clk); check("lat_n0_start", PW'(o_op_start), PW'(0));
      @(negedge clk); check("lat_n1_start", PW'(o_op_start), PW'(0));
      @(negedge clk); check("lat_n2_start", PW'(o_op_start), PW'(1));
      check("lat_cmd", PW'(o_op_cmd), PW'(1));
      check("lat_addr", PW'(o_op_addr), PW'(44'h1000));
      @(negedge clk); check("lat_n3_start", PW'(o_op_start), PW'(0));
      check("lat_wait_state", PW'(o_state), PW'(3));
      @(posedge clk); #1;
      i_op_done = 1'b1;
      tick();
      i_op_done = 1'b0;
      exp_done = 1;
      check("lat_end_state", PW'(o_state), PW'(4));
      check("lat_done_cnt", PW'(o_done_cnt), PW'(exp_done));
      tick();
      check("lat_idle", PW'(o_state), PW'(0));
      check("lat_hold_op", PW'({o_op_cmd, o_op_addr}), PW'({2'd1, 44'h1000}));

      for (int i = 0; i < 5; i++) begin
         push(cv[i].cmd, cv[i].addr, 1'b1);
         if (cv[i].cmd <= 4'd2) run_op(cv[i].err);
         else wait_state(5'd4, "tbl_reach_end");
         exp_done += cv[i].d_done;
         exp_err  += cv[i].d_err;
         wait_state(5'd0, "tbl_idle");
         check("tbl_done_cnt", PW'(o_done_cnt), PW'(exp_done));
         check("tbl_err_cnt", PW'(o_err_cnt), PW'(exp_err));
         check("tbl_drained", PW'(sb.size()), PW'(0));
      end

      // Fill with fetch blocked, overflow push dropped, then drain in order
      i_enable = 1'b0;
      push(4'd0, 44'h100, 1'b1);
      push(4'd1, 44'h200, 1'b1);
      push(4'd2, 44'h300, 1'b1);
      check("fill_ready_3", PW'(o_cmd_ready), PW'(1));
      push(4'd1, 44'h400, 1'b1);
      check("fill_ready_4", PW'(o_cmd_ready), PW'(0));
      check("fill_count_4", PW'(o_cmd_count), PW'(4));
      push(4'd2, 44'h500, 1'b1);
      check("fill_count_5th", PW'(o_cmd_count), PW'(4));
      check("fill_idle", PW'(o_state), PW'(0));
      i_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_op(1'b0);
         wait_state(5'd0, "fill_op_idle");
      end
      exp_done += 4;
      check("fill_done_cnt", PW'(o_done_cnt), PW'(exp_done));
      check("fill_count_0", PW'(o_cmd_count), PW'(0));
      check("fill_drained", PW'(sb.size()), PW'(0));

      // Timeout after TMO cycles in WAIT_DONE
      push(4'd1, 44'h2000, 1'b1);
      wait_state(5'd3, "to_reach_wait");
      n = 0;
      while (o_state == 5'd3 && n < 100) begin
         n++;
         tick();
      end
      exp_err++;
      check("to_cycles", PW'(n), PW'(TMO));
      check("to_end_state", PW'(o_state), PW'(4));
      check("to_err_cnt", PW'(o_err_cnt), PW'(exp_err));
      tick();
      check("to_idle", PW'(o_state), PW'(0));

      // Invalid command followed by POISON
      i_enable = 1'b0;
`ifdef DEVIL_CTRL_FLUSH_ON_ERROR_EN
      push(4'd7, 44'h0, 1'b0);
      push(4'd2, 44'h3000, 1'b0);
`else
      push(4'd7, 44'h0, 1'b0);
      push(4'd2, 44'h3000, 1'b1);
`endif
      starts0 = starts_seen;
      i_enable = 1'b1;
      wait_state(5'd4, "inv_reach_end");
      exp_err++;
      check("inv_no_start", PW'(starts_seen), PW'(starts0));
      check("inv_err_cnt", PW'(o_err_cnt), PW'(exp_err));
      tick();
`ifdef DEVIL_CTRL_FLUSH_ON_ERROR_EN
      check("inv_flush_count", PW'(o_cmd_count), PW'(0));
      tick(); tick(); tick();
      check("inv_flush_idle", PW'(o_state), PW'(0));
      check("inv_flush_no_start", PW'(starts_seen), PW'(starts0));
`else
      check("inv_keep_count", PW'(o_cmd_count), PW'(1));
      run_op(1'b0);
      exp_done++;
      wait_state(5'd0, "inv_idle");
      check("inv_done_cnt", PW'(o_done_cnt), PW'(exp_done));
`endif
      check("inv_drained", PW'(sb.size()), PW'(0));

      for (int i = 0; i < 4; i++) begin
         i_pat_wr_en   = 1'b1;
         i_pat_wr_idx  = pv[i].idx;
         i_pat_wr_data = pv[i].data;
         tick();
         i_pat_wr_en = 1'b0;
         pat_model[pv[i].idx*32 +: 32] = pv[i].data;
         check("pat_top_word", PW'(o_pat[511:480]), PW'(pv[i].exp_top));
         check("pat_full", o_pat, pat_model);
      end

      // Async reset while the start pulse is up, then a stale done
      push(4'd1, 44'h4000, 1'b1);
      wait_state(5'd2, "rst_reach_issue");
      check("pre_rst_start", PW'(o_op_start), PW'(1));
      rst = 1'b1;
      #1;
      check("arst_start", PW'(o_op_start), PW'(0));
      check("arst_state", PW'(o_state), PW'(0));
      check("arst_count", PW'(o_cmd_count), PW'(0));
      check("arst_pat", o_pat, '0);
      check("arst_cnts", PW'({o_done_cnt, o_err_cnt}), PW'(0));
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      i_op_done = 1'b1;
      tick();
      i_op_done = 1'b0;
      tick();
      check("stale_done_cnts", PW'({o_done_cnt, o_err_cnt}), PW'(0));
      check("stale_done_state", PW'(o_state), PW'(0));
      check("final_sb_empty", PW'(sb.size()), PW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
